// File: rtl/mcu_spi_rx.sv
// mcu_spi_rx: MCU-side SPI mode-0 slave, oversampled in the clk domain.
// Reassembles MOSI bytes, strobes each one with a frame-start flag, and
// returns the downstream reply byte on MISO during the following byte slot.
// Optional idle abort: define MCU_SPI_TIMEOUT_EN (threshold TIMEOUT_CYCLES).
// Ports: clk, reset (sync, active-high); spi_ss_n/spi_sck/spi_mosi in;
//   spi_miso out; data_strobe/data_start/data_byte to the control block;
//   reply_byte from it; frame_active, byte_count, timeout_evt status.
module mcu_spi_rx #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_ss_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       data_strobe,
  output logic       data_start,
  output logic [7:0] data_byte,
  input  logic [7:0] reply_byte,
  output logic       frame_active,
  output logic [7:0] byte_count,
  output logic       timeout_evt
);

  localparam logic [1:0] ARMED  = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic ss_meta_q, ss_sync_q, ss_dly_q;
  logic sck_meta_q, sck_sync_q, sck_dly_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic [7:0] data_byte_q, data_byte_d;
  logic       strobe_q, strobe_d;
  logic       start_q, start_d;
  logic       first_q, first_d;
  logic [7:0] byte_count_q, byte_count_d;

  logic ss_fall, ss_rise, sck_rise, sck_fall;
  logic [7:0] rx_next;

  // ss chain resets low so a frame already running at reset
  // keeps the block in ARMED until CS is seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      ss_dly_q    <= 1'b0;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ss_meta_q   <= spi_ss_n;
      ss_sync_q   <= ss_meta_q;
      ss_dly_q    <= ss_sync_q;
      sck_meta_q  <= spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_dly_q   <= sck_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign ss_fall  =  ss_dly_q  & ~ss_sync_q;
  assign ss_rise  = ~ss_dly_q  &  ss_sync_q;
  assign sck_rise = ~sck_dly_q &  sck_sync_q;
  assign sck_fall =  sck_dly_q & ~sck_sync_q;
  assign rx_next  = {rx_q[6:0], mosi_sync_q};

`ifdef MCU_SPI_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        evt_q, evt_d;
  logic        to_hit;

  assign to_hit = (state_q == ACTIVE) && !sck_rise && !sck_fall &&
                  (to_cnt_q == TO_LIMIT);

  always_comb begin
    to_cnt_d = 16'd0;
    evt_d    = 1'b0;
    if (state_q == ACTIVE && !sck_rise && !sck_fall) begin
      if (to_hit) begin
        evt_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= 16'd0;
      evt_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign timeout_evt = evt_q;
`else
  logic to_hit;
  logic unused_to;
  assign to_hit      = 1'b0;
  assign unused_to   = ^TO_LIMIT;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    data_byte_d  = data_byte_q;
    strobe_d     = 1'b0;
    start_d      = start_q;
    first_d      = first_q;
    byte_count_d = byte_count_q;

    unique case (state_q)
      ARMED: begin
        if (ss_sync_q) state_d = IDLE;
      end
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d      = ACTIVE;
          bit_cnt_d    = 3'd0;
          rx_d         = 8'h00;
          tx_d         = 8'h00;
          first_d      = 1'b1;
          byte_count_d = 8'd0;
        end
      end
      ACTIVE: begin
        if (sck_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_byte_d = rx_next;
            strobe_d    = 1'b1;
            start_d     = first_q;
            first_d     = 1'b0;
            if (byte_count_q != 8'hFF)
              byte_count_d = byte_count_q + 8'd1;
          end
        end else if (sck_fall) begin
          // Byte boundary: the reply to the previous byte goes out now.
          if (bit_cnt_q == 3'd0 && byte_count_q != 8'd0) begin
            tx_d   = reply_byte;
            miso_d = reply_byte[7];
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
          end
        end else if (to_hit) begin
          bit_cnt_d    = 3'd0;
          rx_d         = 8'h00;
          tx_d         = 8'h00;
          miso_d       = 1'b0;
          byte_count_d = 8'd0;
          first_d      = 1'b1;
        end
        // A byte completing in the same cycle is still strobed above.
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          miso_d    = 1'b0;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARMED;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      miso_q       <= 1'b0;
      data_byte_q  <= 8'h00;
      strobe_q     <= 1'b0;
      start_q      <= 1'b0;
      first_q      <= 1'b0;
      byte_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      data_byte_q  <= data_byte_d;
      strobe_q     <= strobe_d;
      start_q      <= start_d;
      first_q      <= first_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign spi_miso     = miso_q;
  assign data_strobe  = strobe_q;
  assign data_start   = start_q;
  assign data_byte    = data_byte_q;
  assign frame_active = (state_q == ACTIVE);
  assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_mcu_spi_rx.sv
// tb_mcu_spi_rx: directed bench for mcu_spi_rx.
// Drives SPI mode 0 at clk/8 and checks strobes, MISO and status.
module tb_mcu_spi_rx;

  logic       clk;
  logic       reset;
  logic       spi_ss_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       data_strobe;
  logic       data_start;
  logic [7:0] data_byte;
  logic [7:0] reply_byte;
  logic       frame_active;
  logic [7:0] byte_count;
  logic       timeout_evt;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;

  logic [7:0] got_byte[$];
  logic       got_start[$];
  logic [7:0] reply_q[$];

  mcu_spi_rx #(.TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_ss_n     (spi_ss_n),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .data_strobe  (data_strobe),
    .data_start   (data_start),
    .data_byte    (data_byte),
    .reply_byte   (reply_byte),
    .frame_active (frame_active),
    .byte_count   (byte_count),
    .timeout_evt  (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe logger and reply model: the next reply is presented
  // in the cycle after each strobe.
  initial begin
    reply_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (data_strobe === 1'b1) begin
        strobes++;
        got_byte.push_back(data_byte);
        got_start.push_back(data_start);
        reply_byte = (reply_q.size() > 0) ? reply_q.pop_front() : 8'h00;
      end
    end
  end

  task automatic clear_log();
    strobes = 0;
    got_byte.delete();
    got_start.delete();
    reply_q.delete();
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n,
                          output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      repeat (4) @(negedge clk);
      m = {m[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0] m;
  int         evts;

  initial begin
    reset    = 1'b1;
    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso",   {31'd0, spi_miso},     32'd0);
    check("rst_strobe", {31'd0, data_strobe},  32'd0);
    check("rst_start",  {31'd0, data_start},   32'd0);
    check("rst_byte",   {24'd0, data_byte},    32'd0);
    check("rst_active", {31'd0, frame_active}, 32'd0);
    check("rst_count",  {24'd0, byte_count},   32'd0);
    check("rst_evt",    {31'd0, timeout_evt},  32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Four zero bytes, replies 5C 42 03.
    clear_log();
    reply_q = '{8'h5C, 8'h42, 8'h03};
    cs_low();
    check("t1_active", {31'd0, frame_active}, 32'd1);
    spi_bits(8'h00, 8, m); check("t1_miso0", {24'd0, m}, 32'h00);
    spi_bits(8'h00, 8, m); check("t1_miso1", {24'd0, m}, 32'h5C);
    spi_bits(8'h00, 8, m); check("t1_miso2", {24'd0, m}, 32'h42);
    spi_bits(8'h00, 8, m); check("t1_miso3", {24'd0, m}, 32'h03);
    check("t1_strobes", strobes, 32'd4);
    check("t1_start",
          {28'd0, got_start[0], got_start[1], got_start[2], got_start[3]},
          32'b1000);
    check("t1_count", {24'd0, byte_count}, 32'd4);
    cs_high();
    check("t1_idle", {31'd0, frame_active}, 32'd0);

    // 0x05, 0x01 with reply A6.
    clear_log();
    reply_q = '{8'hA6};
    cs_low();
    spi_bits(8'h05, 8, m);
    spi_bits(8'h01, 8, m); check("t2_miso1", {24'd0, m}, 32'hA6);
    cs_high();
    check("t2_strobes", strobes, 32'd2);
    check("t2_b0", {23'd0, got_start[0], got_byte[0]}, 32'h105);
    check("t2_b1", {23'd0, got_start[1], got_byte[1]}, 32'h001);

    // Partial second byte is dropped.
    clear_log();
    cs_low();
    spi_bits(8'h81, 8, m);
    spi_bits(8'hFF, 5, m);
    cs_high();
    check("t3_strobes", strobes, 32'd1);
    check("t3_b0", {23'd0, got_start[0], got_byte[0]}, 32'h181);
    cs_low();
    spi_bits(8'h7E, 8, m);
    check("t3_strobes2", strobes, 32'd2);
    check("t3_b1", {23'd0, got_start[1], got_byte[1]}, 32'h17E);
    check("t3_count", {24'd0, byte_count}, 32'd1);
    cs_high();

    // Reset mid-frame with CS held low.
    clear_log();
    cs_low();
    spi_bits(8'hA5, 3, m);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_active", {31'd0, frame_active}, 32'd0);
    check("t4_count",  {24'd0, byte_count},   32'd0);
    check("t4_byte",   {24'd0, data_byte},    32'd0);
    check("t4_miso",   {31'd0, spi_miso},     32'd0);
    spi_bits(8'h55, 8, m);
    spi_bits(8'hAA, 8, m);
    check("t4_nostrobe", strobes, 32'd0);
    check("t4_inactive", {31'd0, frame_active}, 32'd0);
    cs_high();
    cs_low();
    spi_bits(8'h99, 8, m);
    cs_high();
    check("t4_strobes", strobes, 32'd1);
    check("t4_b0", {23'd0, got_start[0], got_byte[0]}, 32'h199);

    // Three bits, long stall, then 0x3C.
    clear_log();
    evts = 0;
    cs_low();
    spi_bits(8'hA0, 3, m);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (timeout_evt === 1'b1) evts++;
    end
    spi_bits(8'h3C, 8, m);
    cs_high();
    check("t5_strobes", strobes, 32'd1);
`ifdef MCU_SPI_TIMEOUT_EN
    check("t5_evt", evts, 32'd1);
    check("t5_b0", {23'd0, got_start[0], got_byte[0]}, 32'h13C);
`else
    check("t5_evt", evts, 32'd0);
    check("t5_b0", {23'd0, got_start[0], got_byte[0]}, 32'h1A7);
`endif

    // 300-byte frame at clk/8.
    clear_log();
    cs_low();
    for (int i = 0; i < 300; i++) begin
      spi_bits(8'(i), 8, m);
    end
    check("t6_strobes", strobes, 32'd300);
    check("t6_count", {24'd0, byte_count}, 32'd255);
    check("t6_last", {24'd0, got_byte[299]}, 32'h2B);
    cs_high();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
